// File: rtl/frame_render_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_render_ctrl_if
// Brief    : Draw-engine and VGA-adapter signal bundle for frame_render_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_render_ctrl_if;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [2:0] obj_c;
    logic       obj_done;
    logic [3:0] obj_sel;
    logic       obj_en;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        input  obj_x, obj_y, obj_c, obj_done,
        output obj_sel, obj_en, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output obj_x, obj_y, obj_c, obj_done,
        input  obj_sel, obj_en, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/frame_render_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_render_ctrl
// Brief    : Per-frame sequencer: clears the screen, then walks every object
//            slot through the draw engine and forwards pixels to the VGA port.
// Revision : 1.0 - initial release
// ============================================================================
module frame_render_ctrl #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          FRAME_DIV   = 833333,
    parameter int          NUM_OBJECTS = 6,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    frame_render_ctrl_if.master  bus,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_OBJ   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int               TICK_W     = 20;
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(FRAME_DIV - 1);
    localparam logic [7:0]       c_X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [6:0]       c_Y_LAST   = 7'(SCREEN_H - 1);
    localparam logic [7:0]       c_W        = 8'(SCREEN_W);
    localparam logic [6:0]       c_H        = 7'(SCREEN_H);
    localparam logic [3:0]       c_SEL_LAST = 4'(NUM_OBJECTS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_tick;
    logic              r_pend;
    logic [7:0]        r_cx;
    logic [6:0]        r_cy;
    logic [3:0]        r_sel;
    logic [7:0]        r_vx;
    logic [6:0]        r_vy;
    logic [2:0]        r_vc;
    logic              r_plot;
    logic              w_obj_en;
    logic              w_busy;

    logic w_clear_last;
    logic w_obj_last;
    logic w_in_bounds;

    assign w_clear_last = (r_cx == c_X_LAST) && (r_cy == c_Y_LAST);
    assign w_obj_last   = bus.obj_done && (r_sel == c_SEL_LAST);
    assign w_in_bounds  = (bus.obj_x < c_W) && (bus.obj_y < c_H);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pend)       w_next = S_CLEAR;
            S_CLEAR: if (w_clear_last) w_next = S_OBJ;
            S_OBJ:   if (w_obj_last)   w_next = S_DONE;
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_obj_en = (r_state == S_OBJ);
        w_busy   = (r_state != S_IDLE);
    end

    // Tick counter and pending flag run independently of the frame sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt <= '0;
                r_tick     <= 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                r_tick     <= 1'b0;
            end
            if (r_tick) begin
                r_pend <= 1'b1;
            end else if ((r_state == S_IDLE) && r_pend) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_sel  <= '0;
            r_vx   <= '0;
            r_vy   <= '0;
            r_vc   <= '0;
            r_plot <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cx <= '0;
                    r_cy <= '0;
                end
                S_CLEAR: begin
                    r_vx   <= r_cx;
                    r_vy   <= r_cy;
                    r_vc   <= BG_COLOUR;
                    r_plot <= 1'b1;
                    if (r_cx == c_X_LAST) begin
                        r_cx <= '0;
                        r_cy <= (r_cy == c_Y_LAST) ? 7'd0 : r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                    if (w_clear_last) r_sel <= '0;
                end
                S_OBJ: begin
                    // Off-screen pixels are dropped but the slot sequence still advances.
                    r_vx   <= bus.obj_x;
                    r_vy   <= bus.obj_y;
                    r_vc   <= bus.obj_c;
                    r_plot <= w_in_bounds;
                    if (bus.obj_done && !w_obj_last) r_sel <= r_sel + 4'd1;
                end
                S_DONE: begin
                    r_sel <= '0;
                end
                default: begin
                    r_sel <= '0;
                end
            endcase
        end
    end

    assign bus.obj_sel    = r_sel;
    assign bus.obj_en     = w_obj_en;
    assign bus.vga_x      = r_vx;
    assign bus.vga_y      = r_vy;
    assign bus.vga_colour = r_vc;
    assign bus.vga_plot   = r_plot;
    assign frame_tick     = r_tick;
    assign busy           = w_busy;
    assign overrun        = r_tick & w_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_render_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_render_ctrl
// Brief    : Randomised bench for frame_render_ctrl against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_render_ctrl;
    localparam int FD   = 100;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;
    localparam int NOBJ = 6;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic frame_tick, busy, overrun;
    always #5 clk = ~clk;

    frame_render_ctrl_if bus ();

    frame_render_ctrl #(
        .SCREEN_W(W), .SCREEN_H(H), .FRAME_DIV(FD),
        .NUM_OBJECTS(NOBJ), .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .frame_tick(frame_tick), .busy(busy), .overrun(overrun)
    );

    int tests = 0;
    int fails = 0;

    // Timeline model: a frame is described by its start cycle and object count.
    int n, m_start, m_objs, m_done, frame_no, ecnt;
    bit m_pend, m_act, m_prev_en, rst_done;
    bit cur_tick, cur_busy, cur_en;
    logic [7:0] m_px;
    logic [6:0] m_py;
    logic [2:0] m_pc;

    int first_tick, first_busy, f1_plots, f1_ovr, post_early_plots, post_first_plot;
    int rise_cnt, rise1;
    bit prev_busy;
    logic [17:0] p1, p_last;
    int p1_cyc, p_last_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: actual %0d required %0d", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; m_start = 0; m_objs = 0; m_done = -1;
        m_pend = 0; m_act = 0; m_prev_en = 0;
        m_px = '0; m_py = '0; m_pc = '0;
    endtask

    task automatic compare();
        bit ep;
        int es, k;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        cur_tick = (n > 0) && (n % FD == 0);
        cur_busy = m_act;
        cur_en   = m_act && (n >= m_start + NPIX) && (m_objs < NOBJ);
        es = (m_act && n >= m_start + NPIX) ? ((m_objs > NOBJ - 1) ? NOBJ - 1 : m_objs) : 0;
        k = n - m_start - 1;
        ep = 0; ex = '0; ey = '0; ec = '0;
        if (m_act && k >= 0 && k < NPIX) begin
            ep = 1; ex = 8'(k % W); ey = 7'(k / W); ec = 3'b000;
        end else if (m_prev_en && m_px < W && m_py < H) begin
            ep = 1; ex = m_px; ey = m_py; ec = m_pc;
        end
        chk("frame_tick", frame_tick, cur_tick);
        chk("busy", busy, cur_busy);
        chk("obj_en", bus.obj_en, cur_en);
        chk("obj_sel", bus.obj_sel, es);
        chk("vga_plot", bus.vga_plot, ep);
        chk("overrun", overrun, cur_tick && cur_busy);
        if (ep) begin
            chk("vga_x", bus.vga_x, ex);
            chk("vga_y", bus.vga_y, ey);
            chk("vga_colour", bus.vga_colour, ec);
        end

        if (frame_tick && first_tick < 0) first_tick = n;
        if (busy && first_busy < 0) first_busy = n;
        if (!rst_done) begin
            if (busy && !prev_busy) begin
                rise_cnt++;
                if (rise_cnt == 2) rise1 = n;
            end
            if (frame_no == 1) begin
                if (bus.vga_plot) begin
                    f1_plots++;
                    if (f1_plots == 1)    begin p1 = {bus.vga_x, bus.vga_y, bus.vga_colour}; p1_cyc = n; end
                    if (f1_plots == NPIX) begin p_last = {bus.vga_x, bus.vga_y, bus.vga_colour}; p_last_cyc = n; end
                end
                if (overrun) f1_ovr++;
            end
            if (n == 19303) begin
                chk("lit_pass_x", bus.vga_x, 10);
                chk("lit_pass_y", bus.vga_y, 20);
                chk("lit_pass_c", bus.vga_colour, 3'b100);
                chk("lit_pass_plot", bus.vga_plot, 1);
            end
            if (n == 19308) begin
                chk("lit_clip_plot", bus.vga_plot, 0);
                chk("lit_clip_sel", bus.obj_sel, 1);
            end
            if (n == 19326) begin
                chk("lit_done_busy", busy, 1);
                chk("lit_done_en", bus.obj_en, 0);
                chk("lit_done_sel", bus.obj_sel, 5);
            end
            if (n == 19327) begin
                chk("lit_idle_busy", busy, 0);
                chk("lit_idle_sel", bus.obj_sel, 0);
            end
        end else begin
            if (bus.vga_plot && n <= 102) post_early_plots++;
            if (bus.vga_plot && post_first_plot < 0) post_first_plot = n;
        end
        prev_busy = busy;
    endtask

    task automatic drive();
        if (frame_no == 1 && !rst_done) begin
            bus.obj_c = 3'($urandom_range(0, 7));
            if (bus.obj_en) begin
                bus.obj_done = (ecnt % 4 == 3);
                bus.obj_x = 8'($urandom_range(0, W - 1));
                bus.obj_y = 7'($urandom_range(0, H - 1));
                if (ecnt == 0) begin bus.obj_x = 8'd10;  bus.obj_y = 7'd20; bus.obj_c = 3'b100; end
                if (ecnt == 5) begin bus.obj_x = 8'd165; bus.obj_y = 7'd5; end
                ecnt++;
            end else begin
                bus.obj_done = ($urandom_range(0, 2) == 0);
                bus.obj_x = 8'($urandom_range(0, 255));
                bus.obj_y = 7'($urandom_range(0, 127));
            end
        end else begin
            bus.obj_done = ($urandom_range(0, 3) == 0);
            bus.obj_x = 8'($urandom_range(0, 175));
            bus.obj_y = 7'($urandom_range(0, 127));
            bus.obj_c = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic update();
        bit nxt_pend;
        m_prev_en = cur_en;
        m_px = bus.obj_x; m_py = bus.obj_y; m_pc = bus.obj_c;
        nxt_pend = cur_tick | (m_pend & cur_busy);
        if (cur_en && bus.obj_done) begin
            m_objs++;
            if (m_objs == NOBJ) m_done = n + 1;
        end
        if (m_act && n == m_done) begin
            m_act = 0;
        end else if (!m_act && m_pend) begin
            m_act = 1; m_start = n + 1; m_objs = 0; m_done = -1;
            frame_no++;
        end
        m_pend = nxt_pend;
    endtask

    task automatic step();
        @(negedge clk);
        n++;
        compare();
        drive();
        update();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.obj_x = '0; bus.obj_y = '0; bus.obj_c = '0; bus.obj_done = 1'b0;
        model_reset();
        frame_no = 0; ecnt = 0; rst_done = 0;
        first_tick = -1; first_busy = -1; f1_plots = 0; f1_ovr = 0;
        rise_cnt = 0; rise1 = -1; prev_busy = 0;
        p1 = '1; p_last = '1; p1_cyc = -1; p_last_cyc = -1;
        post_early_plots = 0; post_first_plot = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_vga_x", bus.vga_x, 0);
        chk("rst_vga_y", bus.vga_y, 0);
        chk("rst_vga_colour", bus.vga_colour, 0);
        compare();
        drive();
        update();

        for (int c = 0; c < 90000 && !(frame_no == 3 && bus.obj_en && bus.obj_sel == 3); c++) step();
        chk("reached_frame3_sel3", {31'd0, (frame_no == 3 && bus.obj_sel == 3)}, 1);

        chk("lit_first_tick", first_tick, 100);
        chk("lit_first_busy", first_busy, 102);
        chk("lit_first_plot_cyc", p1_cyc, 103);
        chk("lit_first_plot_pix", p1, {8'd0, 7'd0, 3'b000});
        chk("lit_last_clear_cyc", p_last_cyc, 19302);
        chk("lit_last_clear_pix", p_last, {8'd159, 7'd119, 3'b000});
        chk("lit_f1_plots", f1_plots, NPIX + 23);
        chk("lit_f1_overruns", f1_ovr, 192);
        chk("lit_f2_start", rise1, 19328);

        #2;
        resetn = 1'b0;
        #1;
        chk("arst_vga_plot", bus.vga_plot, 0);
        chk("arst_vga_x", bus.vga_x, 0);
        chk("arst_vga_y", bus.vga_y, 0);
        chk("arst_vga_colour", bus.vga_colour, 0);
        chk("arst_obj_sel", bus.obj_sel, 0);
        chk("arst_obj_en", bus.obj_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tick", frame_tick, 0);
        chk("arst_overrun", overrun, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        rst_done = 1; frame_no = 10;
        first_tick = -1; first_busy = -1;
        compare();
        drive();
        update();
        repeat (250) step();
        chk("lit_post_first_tick", first_tick, 100);
        chk("lit_post_first_busy", first_busy, 102);
        chk("lit_post_early_plots", post_early_plots, 0);
        chk("lit_post_first_plot", post_first_plot, 103);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
